mem_ctrl: RTL

- Arbiter and sequencer for the single byte-wide synchronous RAM port shared by instruction fetch (IF) and the load/store path (MEM).
- Serialises each 1/2/4-byte access into per-byte RAM cycles and assembles or disassembles 32-bit little-endian words.
- Raises stall requests to the pipeline controller while a requester is waiting.
- Sits between the if/mem pipeline stages and the external RAM.

---
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter and sequencer shared by instruction fetch and load/store
//
// Each 1/2/4-byte access is broken into one RAM cycle per byte. Bytes are
// little-endian: byte k of the word lives at base + k.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_req_i          IF requests a 4-byte read, held until if_done_o
//   if_addr_i         IF byte address
//   if_done_o         one-cycle pulse, if_data_o valid
//   if_data_o         last fetched word (held between fetches)
//   mem_req_i         MEM requests an access, held until mem_done_o
//   mem_we_i          1 = store, 0 = load
//   mem_width_i       00 byte, 01 half, 1x word
//   mem_addr_i        MEM byte address
//   mem_wdata_i       store data, low byte first
//   mem_done_o        one-cycle pulse, access complete
//   mem_rdata_o       last load result, zero-extended (held between loads)
//   if_stall_req_o    IF waiting
//   mem_stall_req_o   MEM waiting
//   ram_addr_o        RAM byte address (0 when no byte cycle is active)
//   ram_dout_o        RAM write byte
//   ram_wr_o          RAM write strobe
//   ram_din_i         RAM read byte, valid the cycle after its address

module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_width_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  output logic              if_stall_req_o,
  output logic              mem_stall_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        cnt;        // byte cycle index, runs 0..N
  logic [2:0]        n;          // bytes in the current access
  logic [ADDR_W-1:0] base;
  logic              we;
  logic              owner_mem;  // 1 = MEM owns the access, 0 = IF
  logic [31:0]       wdata;
  logic [31:0]       rd_buf;     // partially assembled read word
  logic [31:0]       buf_next;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic [2:0]        mem_n;
  logic [1:0]        lane;

  assign mem_n = (mem_width_i == 2'b00) ? 3'd1 :
                 (mem_width_i == 2'b01) ? 3'd2 : 3'd4;

  // The byte arriving now belongs to the address presented last cycle,
  // hence lane cnt-1.
  assign lane = cnt[1:0] - 2'd1;

  always_comb begin
    buf_next = rd_buf;
    buf_next[{lane, 3'b000} +: 8] = ram_din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      n           <= 3'd0;
      base        <= '0;
      we          <= 1'b0;
      owner_mem   <= 1'b0;
      wdata       <= 32'd0;
      rd_buf      <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt    <= 3'd0;
          rd_buf <= 32'd0;
          if (mem_req_i) begin
            state     <= S_BUSY;
            owner_mem <= 1'b1;
            n         <= mem_n;
            we        <= mem_we_i;
            wdata     <= mem_wdata_i;
            base      <= mem_addr_i[ADDR_W-1:0];
          end else if (if_req_i) begin
            state     <= S_BUSY;
            owner_mem <= 1'b0;
            n         <= 3'd4;
            we        <= 1'b0;
            wdata     <= 32'd0;
            base      <= if_addr_i[ADDR_W-1:0];
          end
        end
        S_BUSY: begin
          cnt <= cnt + 3'd1;
          if (we) begin
            if (cnt == n - 3'd1) state <= S_DONE;
          end else begin
            if (cnt != 3'd0) rd_buf <= buf_next;
            // Last byte lands straight in the owner's output register so
            // it is valid during DONE; the other owner's value is untouched.
            if (cnt == n) begin
              state <= S_DONE;
              if (owner_mem) mem_rdata_q <= buf_next;
              else           if_data_q   <= buf_next;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= 3'd0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr_o = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'd0;
    if (state == S_BUSY && cnt < n) begin
      ram_addr_o = base + ADDR_W'(cnt);
      ram_wr_o   = we;
      if (we) ram_dout_o = wdata[{cnt[1:0], 3'b000} +: 8];
    end
  end

  assign if_done_o       = (state == S_DONE) && !owner_mem;
  assign mem_done_o      = (state == S_DONE) && owner_mem;
  assign if_data_o       = if_data_q;
  assign mem_rdata_o     = mem_rdata_q;
  assign if_stall_req_o  = if_req_i & ~if_done_o;
  assign mem_stall_req_o = mem_req_i & ~mem_done_o;

endmodule
